// File: rtl/grid_mover.sv
// Grid mover: steps a position across a GRID_W x GRID_H grid, turning toward
// latched direction requests and checking each target cell against a wall map.
module grid_mover #(
  parameter int GRID_W  = 21,
  parameter int GRID_H  = 21,
  parameter int CW      = 5,
  parameter int START_X = 10,
  parameter int START_Y = 12,
  parameter int WRAP_EN = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic          step,
  output logic          wall_req,
  output logic [CW-1:0] wall_x,
  output logic [CW-1:0] wall_y,
  input  logic          wall_ack,
  input  logic          wall_blocked,
  output logic [CW-1:0] curr_x,
  output logic [CW-1:0] curr_y,
  output logic [1:0]    heading,
  output logic          moving,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TURN = 2'd1;
  localparam logic [1:0] S_FWD  = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_x, r_y, r_wx, r_wy;
  logic [1:0]    r_head, r_pdir;
  logic          r_mov, r_pvld, r_off;

  logic          w_one;
  logic [1:0]    w_ndir, w_cdir;
  logic          w_c_off, w_h_off, w_done, w_blk;
  logic [CW-1:0] w_c_x, w_c_y, w_h_x, w_h_y;

  // Neighbour of (x,y) along dir; off flags an edge crossing with wrap disabled.
  function automatic logic [2*CW:0] next_cell(input logic [1:0] dir,
                                              input logic [CW-1:0] x,
                                              input logic [CW-1:0] y);
    logic [CW-1:0] tx, ty;
    logic          off;
    tx  = x;
    ty  = y;
    off = 1'b0;
    case (dir)
      2'd0: if (y == '0) begin ty = CW'(GRID_H-1); off = (WRAP_EN == 0); end
            else ty = y - CW'(1);
      2'd1: if (x == CW'(GRID_W-1)) begin tx = '0; off = (WRAP_EN == 0); end
            else tx = x + CW'(1);
      2'd2: if (y == CW'(GRID_H-1)) begin ty = '0; off = (WRAP_EN == 0); end
            else ty = y + CW'(1);
      default: if (x == '0) begin tx = CW'(GRID_W-1); off = (WRAP_EN == 0); end
               else tx = x - CW'(1);
    endcase
    return {off, tx, ty};
  endfunction

  always_comb begin
    w_one  = ($countones({up, right, down, left}) == 1);
    w_ndir = 2'd3;
    if (up)         w_ndir = 2'd0;
    else if (right) w_ndir = 2'd1;
    else if (down)  w_ndir = 2'd2;
    w_cdir = r_pvld ? r_pdir : r_head;
    {w_c_off, w_c_x, w_c_y} = next_cell(w_cdir, r_x, r_y);
    {w_h_off, w_h_x, w_h_y} = next_cell(r_head, r_x, r_y);
    // An off-grid target resolves as blocked one cycle after state entry.
    w_done = (r_state != S_IDLE) && (r_off || wall_ack);
    w_blk  = r_off || wall_blocked;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x     <= CW'(START_X);
      r_y     <= CW'(START_Y);
      r_head  <= 2'd0;
      r_mov   <= 1'b0;
      r_pvld  <= 1'b0;
      r_pdir  <= 2'd0;
      r_wx    <= '0;
      r_wy    <= '0;
      r_off   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (step && (r_pvld || r_mov)) begin
          r_state <= r_pvld ? S_TURN : S_FWD;
          r_wx    <= w_c_x;
          r_wy    <= w_c_y;
          r_off   <= w_c_off;
        end
        S_TURN: if (w_done) begin
          if (!w_blk) begin
            r_x     <= r_wx;
            r_y     <= r_wy;
            r_head  <= r_pdir;
            r_mov   <= 1'b1;
            r_pvld  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_mov) begin
            r_state <= S_FWD;
            r_wx    <= w_h_x;
            r_wy    <= w_h_y;
            r_off   <= w_h_off;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FWD: if (w_done) begin
          if (!w_blk) begin
            r_x <= r_wx;
            r_y <= r_wy;
          end else begin
            r_mov <= 1'b0;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Placed last so a fresh request beats the clear on a successful turn.
      if (w_one) begin
        r_pvld <= 1'b1;
        r_pdir <= w_ndir;
      end
    end
  end

  assign wall_req = (r_state != S_IDLE) && !r_off;
  assign wall_x   = r_wx;
  assign wall_y   = r_wy;
  assign curr_x   = r_x;
  assign curr_y   = r_y;
  assign heading  = r_head;
  assign moving   = r_mov;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_grid_mover.sv
// Scoreboard bench for grid_mover: a wrapping instance and a non-wrapping one.
module tb_grid_mover;
  localparam int GW = 21;
  localparam int GH = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, up, down, left, right, step, wall_ack, wall_blocked, sel;
  logic       req_a, mv_a, busy_a, req_b, mv_b, busy_b;
  logic [4:0] wx_a, wy_a, cx_a, cy_a, wx_b, wy_b, cx_b, cy_b;
  logic [1:0] hd_a, hd_b;

  grid_mover u_a (
    .clk(clk), .reset(reset),
    .up(up & ~sel), .down(down & ~sel), .left(left & ~sel), .right(right & ~sel),
    .step(step & ~sel), .wall_req(req_a), .wall_x(wx_a), .wall_y(wy_a),
    .wall_ack(wall_ack & ~sel), .wall_blocked(wall_blocked),
    .curr_x(cx_a), .curr_y(cy_a), .heading(hd_a), .moving(mv_a), .busy(busy_a));

  grid_mover #(.START_X(0), .START_Y(3), .WRAP_EN(0)) u_b (
    .clk(clk), .reset(reset),
    .up(up & sel), .down(down & sel), .left(left & sel), .right(right & sel),
    .step(step & sel), .wall_req(req_b), .wall_x(wx_b), .wall_y(wy_b),
    .wall_ack(wall_ack & sel), .wall_blocked(wall_blocked),
    .curr_x(cx_b), .curr_y(cy_b), .heading(hd_b), .moving(mv_b), .busy(busy_b));

  logic       o_req, o_mv, o_busy;
  logic [4:0] o_wx, o_wy, o_cx, o_cy;
  logic [1:0] o_hd;
  assign o_req  = sel ? req_b  : req_a;
  assign o_mv   = sel ? mv_b   : mv_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_wx   = sel ? wx_b   : wx_a;
  assign o_wy   = sel ? wy_b   : wy_a;
  assign o_cx   = sel ? cx_b   : cx_a;
  assign o_cy   = sel ? cy_b   : cy_a;
  assign o_hd   = sel ? hd_b   : hd_a;

  typedef struct { int x; int y; bit blk; } q_t;
  q_t sb[$];

  int n_chk = 0, n_fail = 0;
  int m_x, m_y, m_h, m_pd;
  bit m_mv, m_pv;
  int lat_fix = 0;
  bit busy_step = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void tgt(input int h, input int x, input int y, input bit wrap,
                              output int tx, output int ty, output bit off);
    tx = x; ty = y; off = 1'b0;
    case (h)
      0: ty = y - 1;
      1: tx = x + 1;
      2: ty = y + 1;
      default: tx = x - 1;
    endcase
    if (tx < 0 || tx >= GW || ty < 0 || ty >= GH) begin
      off = !wrap;
      tx = (tx + GW) % GW;
      ty = (ty + GH) % GH;
    end
  endfunction

  task automatic set_dir(input int d, input logic v);
    case (d)
      0: up = v;
      1: right = v;
      2: down = v;
      default: left = v;
    endcase
  endtask

  task automatic pulse_dir(input int d);
    @(negedge clk); set_dir(d, 1'b1);
    @(negedge clk); set_dir(d, 1'b0);
    m_pv = 1'b1; m_pd = d;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_x"}, 32'(o_cx), 32'(m_x));
    chk({tag, "_y"}, 32'(o_cy), 32'(m_y));
    chk({tag, "_hd"}, 32'(o_hd), 32'(m_h));
    chk({tag, "_mv"}, 32'(o_mv), 32'(m_mv));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    m_x = sel ? 0 : 10; m_y = sel ? 3 : 12;
    m_h = 0; m_mv = 1'b0; m_pv = 1'b0; m_pd = 0;
    chk_state(tag);
    chk({tag, "_req"}, 32'(o_req), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_wx"}, 32'(o_wx), 0);
    chk({tag, "_wy"}, 32'(o_wy), 0);
  endtask

  // Model one step, queue the expected queries, then answer them as the DUT asks.
  task automatic do_step(input string tag, input bit b0, input bit b1, input int late_dir);
    int tx, ty, cnt, lat;
    bit off, blk;
    q_t e;
    sb.delete();
    if (m_pv) begin
      tgt(m_pd, m_x, m_y, !sel, tx, ty, off);
      blk = off | b0;
      if (!off) sb.push_back('{tx, ty, b0});
      if (!blk) begin
        m_x = tx; m_y = ty; m_h = m_pd; m_mv = 1'b1; m_pv = 1'b0;
        if (late_dir >= 0) begin m_pv = 1'b1; m_pd = late_dir; end
      end else if (m_mv) begin
        tgt(m_h, m_x, m_y, !sel, tx, ty, off);
        blk = off | b1;
        if (!off) sb.push_back('{tx, ty, b1});
        if (!blk) begin m_x = tx; m_y = ty; end else m_mv = 1'b0;
      end
    end else if (m_mv) begin
      tgt(m_h, m_x, m_y, !sel, tx, ty, off);
      blk = off | b0;
      if (!off) sb.push_back('{tx, ty, b0});
      if (!blk) begin m_x = tx; m_y = ty; end else m_mv = 1'b0;
    end
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_noreq0"}, 32'(o_req), 0);
      @(negedge clk);
      chk({tag, "_noreq1"}, 32'(o_req), 0);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cnt = 0;
      while (!o_req && cnt < 20) begin @(negedge clk); cnt++; end
      chk({tag, "_req_seen"}, 32'(o_req), 1);
      chk({tag, "_qx"}, 32'(o_wx), 32'(e.x));
      chk({tag, "_qy"}, 32'(o_wy), 32'(e.y));
      lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
      for (int i = 1; i < lat; i++) begin
        @(negedge clk);
        step = busy_step && (i == 1);
        chk({tag, "_hold_req"}, 32'(o_req), 1);
        chk({tag, "_hold_qx"}, 32'(o_wx), 32'(e.x));
        chk({tag, "_hold_qy"}, 32'(o_wy), 32'(e.y));
      end
      step = 1'b0;
      wall_ack = 1'b1; wall_blocked = e.blk;
      if (late_dir >= 0 && sb.size() == 0) set_dir(late_dir, 1'b1);
      @(negedge clk);
      wall_ack = 1'b0; wall_blocked = 1'b0;
      if (late_dir >= 0) set_dir(late_dir, 1'b0);
    end
    chk({tag, "_busy_end"}, 32'(o_busy), 0);
    chk({tag, "_req_end"}, 32'(o_req), 0);
    @(negedge clk);
    chk({tag, "_req_idle"}, 32'(o_req), 0);
    chk_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; up = 0; down = 0; left = 0; right = 0; step = 0;
    wall_ack = 0; wall_blocked = 0; sel = 1'b0;
    do_reset("rst_a");

    // Left turn from reset position with a two-cycle ack.
    lat_fix = 2;
    pulse_dir(3);
    do_step("left", 1'b0, 1'b0, -1);
    chk("left_cx", 32'(o_cx), 9);
    chk("left_cy", 32'(o_cy), 12);
    chk("left_hd", 32'(o_hd), 3);
    chk("left_mv", 32'(o_mv), 1);
    lat_fix = 0;

    // Blocked turn falls through to a forward move; pending stays alive.
    pulse_dir(0);
    do_step("turnblk", 1'b1, 1'b0, -1);
    chk("turnblk_cx", 32'(o_cx), 8);
    chk("turnblk_hd", 32'(o_hd), 3);
    do_step("pendkeep", 1'b0, 1'b0, -1);
    pulse_dir(0);
    do_step("samedir", 1'b0, 1'b0, -1);

    // Forward blocked stops the mover; further steps are silent.
    pulse_dir(2);
    do_step("down", 1'b0, 1'b0, -1);
    do_step("fwdblk", 1'b1, 1'b0, -1);
    chk("fwdblk_mv", 32'(o_mv), 0);
    do_step("idle", 1'b0, 1'b0, -1);

    // New direction coinciding with the pending clear survives.
    pulse_dir(1);
    do_step("late", 1'b0, 1'b0, 0);
    do_step("late_use", 1'b0, 1'b0, -1);

    // Step while busy is dropped.
    busy_step = 1'b1; lat_fix = 3;
    do_step("drop", 1'b0, 1'b0, -1);
    busy_step = 1'b0; lat_fix = 0;

    // Walk to (20,5) and wrap across both axes.
    do_reset("rst_a2");
    pulse_dir(0);
    repeat (7) do_step("walk_up", 1'b0, 1'b0, -1);
    pulse_dir(1);
    repeat (11) do_step("walk_rt", 1'b0, 1'b0, -1);
    chk("wrapx_cx", 32'(o_cx), 0);
    chk("wrapx_cy", 32'(o_cy), 5);
    pulse_dir(0);
    repeat (6) do_step("walk_up2", 1'b0, 1'b0, -1);
    chk("wrapy_cy", 32'(o_cy), 20);
    pulse_dir(3);
    do_step("wrapl", 1'b0, 1'b0, -1);
    chk("wrapl_cx", 32'(o_cx), 20);

    // Reset in the middle of a query; the late ack is ignored.
    do_reset("rst_a3");
    pulse_dir(1);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    chk("midrst_req", 32'(o_req), 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_req_low", 32'(o_req), 0);
    wall_ack = 1'b1;
    @(negedge clk); wall_ack = 1'b0;
    @(negedge clk);
    m_x = 10; m_y = 12; m_h = 0; m_mv = 1'b0; m_pv = 1'b0;
    chk("midrst_req_after", 32'(o_req), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk_state("midrst");

    // Non-wrapping instance at the left edge.
    sel = 1'b1;
    do_reset("rst_b");
    pulse_dir(3);
    do_step("nowrap", 1'b0, 1'b0, -1);
    chk("nowrap_cx", 32'(o_cx), 0);
    chk("nowrap_cy", 32'(o_cy), 3);
    chk("nowrap_mv", 32'(o_mv), 0);
    pulse_dir(1);
    do_step("nw_right", 1'b0, 1'b0, -1);
    pulse_dir(3);
    do_step("nw_back", 1'b0, 1'b0, -1);
    do_step("nw_fwdoff", 1'b0, 1'b0, -1);
    chk("nw_fwdoff_mv", 32'(o_mv), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
